// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the fetch-address generator: state codes, control
// polarities, default bus widths and reset vector.
package pc_fetch_gen_pkg;

  localparam int unsigned InstAddrBus = 64;
  localparam int unsigned InstBus     = 32;

  localparam logic [63:0] RESET_VEC_DEF = 64'h8000_0000;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Branch      = 1'b1;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t BOOT = 2'd0;
  localparam fetch_state_t REQ  = 2'd1;
  localparam fetch_state_t WAIT = 2'd2;
  localparam fetch_state_t HOLD = 2'd3;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority redirect select (trap over branch) with target alignment.
module pc_redirect_mux
  import pc_fetch_gen_pkg::*;
#(
  parameter int unsigned XLEN       = InstAddrBus,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic            br_sel,
  input  logic [XLEN-1:0] br_tgt,
  input  logic            trap_sel,
  input  logic [XLEN-1:0] trap_tgt,
  output logic            redir,
  output logic [XLEN-1:0] tgt
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  always_comb begin
    redir = trap_sel | br_sel;
    tgt   = (trap_sel ? trap_tgt : br_tgt) & ALIGN_MASK;
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: one-outstanding valid/ready instruction requests,
// redirect handling with stale-response kill, and a one-entry decode buffer.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = InstAddrBus,
  parameter int unsigned     ILEN       = InstBus,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_sel_i,
  input  logic [XLEN-1:0] br_tgt_i,
  input  logic            trap_sel_i,
  input  logic [XLEN-1:0] trap_tgt_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            rsp_valid_i,
  input  logic [ILEN-1:0] rsp_inst_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] pc_o,
  output logic            ce_o
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic            ce;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  logic            redir;
  logic [XLEN-1:0] tgt;

  pc_redirect_mux #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_redirect_mux (
    .br_sel   (br_sel_i),
    .br_tgt   (br_tgt_i),
    .trap_sel (trap_sel_i),
    .trap_tgt (trap_tgt_i),
    .redir    (redir),
    .tgt      (tgt)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      kill       <= 1'b0;
      ce         <= ChipDisable;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          ce    <= ChipEnable;
          state <= REQ;
          if (redir == Branch) pc <= tgt;
        end
        REQ: begin
          if (redir == Branch) pc <= tgt;
          // A redirect coinciding with the handshake still sends the request;
          // its response must be dropped when it returns.
          if (req_ready_i) begin
            kill  <= redir;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid_i) begin
            kill  <= 1'b0;
            state <= REQ;
            if (!kill && redir != Branch) begin
              inst       <= rsp_inst_i;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + XLEN'(STEP);
              state      <= HOLD;
            end else if (redir == Branch) begin
              pc <= tgt;
            end
          end else if (redir == Branch) begin
            kill <= 1'b1;
            pc   <= tgt;
          end
        end
        HOLD: begin
          if (redir == Branch) begin
            inst_valid <= 1'b0;
            pc         <= tgt;
            state      <= REQ;
          end else if (inst_ready_i) begin
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign req_valid_o  = (state == REQ);
  assign req_addr_o   = pc;
  assign pc_o         = pc;
  assign ce_o         = ce;
  assign inst_valid_o = inst_valid;
  assign inst_o       = inst;
  assign inst_pc_o    = inst_pc;

endmodule
